serial_divider: RTL and testbench

Parametrised multi-cycle integer divider, the successor to the single-bit divide/negate bitslice. It generalises the DIVH/DIVL shift-subtract datapath to WIDTH bits with a built-in controller, and uses one-hot-free two's-complement negation stages for signed operation. It sits beside the ALU and exchanges operands and results through a Start/Done handshake.

---
 rtl/serial_divider.sv | 137 +++++++++++++
 tb/tb_serial_divider.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - multi-cycle shift-subtract integer divider with Start/Done handshake
// Optional two's-complement operation when SERIAL_DIVIDER_SIGNED_EN is defined.
module serial_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divh;
    logic [WIDTH-1:0] divl;
    logic [WIDTH-1:0] divisor;
    logic             zero_flag;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef SERIAL_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    always_comb begin
        mag1  = Operand1[WIDTH-1] ? negate(Operand1) : Operand1;
        mag2  = Operand2[WIDTH-1] ? negate(Operand2) : Operand2;
        q_fix = neg_q ? negate(divl) : divl;
        r_fix = neg_r ? negate(divh) : divh;
    end
`else
    always_comb begin
        mag1  = Operand1;
        mag2  = Operand2;
        q_fix = divl;
        r_fix = divh;
    end
`endif

    // Trial subtraction carries one extra bit so its MSB is the borrow.
    always_comb begin
        shifted = {divh, divl[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            divh      <= '0;
            divl      <= '0;
            divisor   <= '0;
            zero_flag <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        divh    <= '0;
                        divisor <= mag2;
                        count   <= CW'(WIDTH);
                        Busy    <= 1'b1;
`ifdef SERIAL_DIVIDER_SIGNED_EN
                        neg_q   <= Operand1[WIDTH-1] ^ Operand2[WIDTH-1];
                        neg_r   <= Operand1[WIDTH-1];
`endif
                        // On divide-by-zero DIVL keeps the raw dividend for Remainder.
                        if (Operand2 == '0) begin
                            zero_flag <= 1'b1;
                            divl      <= Operand1;
                            state     <= FIX;
                        end else begin
                            zero_flag <= 1'b0;
                            divl      <= mag1;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        divh <= trial[WIDTH-1:0];
                        divl <= {divl[WIDTH-2:0], 1'b1};
                    end else begin
                        divh <= shifted[WIDTH-1:0];
                        divl <= {divl[WIDTH-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    DivZero <= zero_flag;
                    if (zero_flag) begin
                        Quotient  <= '1;
                        Remainder <= divl;
                    end else begin
                        Quotient  <= q_fix;
                        Remainder <= r_fix;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_divider.sv
// tb/tb_serial_divider.sv - directed self-checking bench for serial_divider (WIDTH=8)
module tb_serial_divider;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Operand1 = '0;
    logic [7:0] Operand2 = '0;
    logic       Busy;
    logic       Done;
    logic       DivZero;
    logic [7:0] Quotient;
    logic [7:0] Remainder;

    int checks = 0;
    int failures = 0;

    serial_divider #(.WIDTH(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero),
        .Quotient (Quotient),
        .Remainder(Remainder)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issues one division starting #1 after a rising edge; pulse_at injects a stray Start.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez,
                           input int elat, input int pulse_at);
        int  lat;
        int  busy_cnt;
        bit  got_done;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        @(posedge Clock); #1;
        Start    = 1'b0;
        Operand1 = 8'h5A;
        Operand2 = 8'h33;
        check({tag, "_done_clr"}, Done, 0);
        busy_cnt = Busy ? 1 : 0;
        lat      = 0;
        got_done = 1'b0;
        for (int e = 1; e <= 40 && !got_done; e++) begin
            if (pulse_at == e) begin
                Start    = 1'b1;
                Operand1 = 8'd50;
                Operand2 = 8'd5;
            end
            @(posedge Clock); #1;
            Start = 1'b0;
            if (Done) begin
                got_done = 1'b1;
                lat      = e;
            end else if (Busy) begin
                busy_cnt++;
            end
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, busy_cnt, elat);
        check({tag, "_busy_done"}, Busy, 0);
        check({tag, "_q"}, Quotient, eq);
        check({tag, "_r"}, Remainder, er);
        check({tag, "_dz"}, DivZero, ez);
    endtask

    int done_seen;

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_dz", DivZero, 0);
        check("rst_q", Quotient, 0);
        check("rst_r", Remainder, 0);
        Reset = 1'b0;

        run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 0);
`ifdef SERIAL_DIVIDER_SIGNED_EN
        run_div("dm100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 9, 0);
        run_div("d100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9, 0);
        run_div("dmin_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 0);
`else
        run_div("d156_7", 8'h9C, 8'h07, 8'd22, 8'd2, 1'b0, 9, 0);
        run_div("d100_249", 8'd100, 8'hF9, 8'h00, 8'd100, 1'b0, 9, 0);
        run_div("d128_255", 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9, 0);
`endif
        run_div("d7_100", 8'd7, 8'd100, 8'd0, 8'd7, 1'b0, 9, 0);
        run_div("d55_0", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 1, 0);
        run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 0);
`ifdef SERIAL_DIVIDER_SIGNED_EN
        run_div("d200_9_pulse", 8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0, 9, 4);
`else
        run_div("d200_9_pulse", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9, 4);
`endif

        // Reset sampled at edge 5 of a running division.
        Operand1 = 8'd100;
        Operand2 = 8'd7;
        Start    = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (4) begin
            @(posedge Clock); #1;
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_dz", DivZero, 0);
        check("midrst_q", Quotient, 0);
        check("midrst_r", Remainder, 0);
        done_seen = 0;
        repeat (12) begin
            @(posedge Clock); #1;
            if (Done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_div("after_rst_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
